// File: rtl/axis_fifo_wr_arbiter_pkg.sv
// Shared definitions for the stream FIFO write-port arbiter.
//   - arb_state_e : two-state arbiter FSM encoding (idle / grant held)
//   - clog2       : ceiling log2, usable in parameter expressions
//   - DefaultDataWidth : default per-source TDATA width
package axis_fifo_wr_arbiter_pkg;

    localparam int unsigned DefaultDataWidth = 32;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_fifo_wr_arbiter_rr_priority_picker.sv
// Combinational round-robin selector.
//   req      : request vector, one bit per source
//   last_idx : index of the previously granted source
//   any_req  : at least one request bit is set
//   next_idx : first requester scanning upward from last_idx+1, wrapping
module rr_priority_picker
    import axis_fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   last_idx,
    output logic              any_req,
    output logic [IdxW-1:0]   next_idx
);

    localparam int N = int'(NumReq);

    logic found;
    int   idx;

    always_comb begin
        any_req  = |req;
        next_idx = last_idx;
        found    = 1'b0;
        idx      = 0;
        // Offset 1 first, so the most recently served source has lowest priority.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_idx) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                next_idx = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/axis_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between several AXI4-Stream sinks.
// A grant is held for a whole packet (through TLAST) or C_MAX_BURST beats.
//   S_AXIS_ACLK / S_AXIS_ARESETN : clock, asynchronous active-low reset
//   S_AXIS_TDATA/TVALID/TLAST    : flattened per-source stream inputs
//   S_AXIS_TREADY                : per-source ready, only the granted bit can be high
//   fifo_wdata/fifo_wlast/fifo_wr_en : FIFO write port, driven by the granted source
//   fifo_full                    : FIFO full, blocks the granted source
//   arb_busy / arb_grant         : grant held / current or last granted index
module axis_fifo_wr_arbiter
    import axis_fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = DefaultDataWidth,
    parameter int unsigned C_NUM_SRC            = 4,
    parameter int unsigned C_MAX_BURST          = 16
) (
    input  logic                                      S_AXIS_ACLK,
    input  logic                                      S_AXIS_ARESETN,
    input  logic [C_NUM_SRC*C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [C_NUM_SRC-1:0]                      S_AXIS_TVALID,
    input  logic [C_NUM_SRC-1:0]                      S_AXIS_TLAST,
    output logic [C_NUM_SRC-1:0]                      S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]           fifo_wdata,
    output logic                                      fifo_wlast,
    output logic                                      fifo_wr_en,
    input  logic                                      fifo_full,
    output logic                                      arb_busy,
    output logic [clog2(C_NUM_SRC)-1:0]               arb_grant
);

    localparam int unsigned W  = C_S_AXIS_TDATA_WIDTH;
    localparam int unsigned GW = clog2(C_NUM_SRC);
    localparam int unsigned CW = clog2(C_MAX_BURST) + 1;

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          any_req;
    logic [GW-1:0] next_idx;
    logic          sel_valid;
    logic          sel_last;
    logic [W-1:0]  sel_data;

    rr_priority_picker #(
        .NumReq (C_NUM_SRC),
        .IdxW   (GW)
    ) u_picker (
        .req      (S_AXIS_TVALID),
        .last_idx (grant_q),
        .any_req  (any_req),
        .next_idx (next_idx)
    );

    // Source mux on the registered grant index.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(C_NUM_SRC); i++) begin
            if (GW'(i) == grant_q) begin
                sel_valid = S_AXIS_TVALID[i];
                sel_last  = S_AXIS_TLAST[i];
                sel_data  = S_AXIS_TDATA[i*W +: W];
            end
        end
    end

    // Ready/write strobe are combinational from fifo_full so a full FIFO
    // blocks a transfer in the very cycle it rises.
    always_comb begin
        arb_busy      = (state_q == StGrant);
        arb_grant     = grant_q;
        S_AXIS_TREADY = '0;
        for (int i = 0; i < int'(C_NUM_SRC); i++) begin
            if (arb_busy && (GW'(i) == grant_q)) begin
                S_AXIS_TREADY[i] = ~fifo_full;
            end
        end
        fifo_wr_en = arb_busy & sel_valid & ~fifo_full;
        fifo_wdata = arb_busy ? sel_data : '0;
        fifo_wlast = arb_busy & sel_last;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = next_idx;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // Only accepted beats advance; a stalled or blocked cycle freezes everything.
                if (fifo_wr_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (sel_last || (cnt_d == CW'(C_MAX_BURST))) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q <= StIdle;
            // Last grant at the top index makes source 0 the first winner.
            grant_q <= GW'(C_NUM_SRC - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
